// File: rtl/uart_pkg.sv
// Shared definitions for the Hamming(7,4) UART receive byte controller.
//   - codeword / nibble widths
//   - Hamming position-to-bit index constants (position p lives in c[p-1])
//   - pairing FSM state type
//   - hamming74_decode: single-error-correcting decode returning
//     {syn_nonzero, nibble}
package uart_pkg;

  localparam int CW_W  = 7;
  localparam int NIB_W = 4;

  // Parity bits sit at positions 1, 2 and 4; data bits at 3, 5, 6 and 7.
  localparam int P1_IDX = 0;
  localparam int P2_IDX = 1;
  localparam int D0_IDX = 2;
  localparam int P4_IDX = 3;
  localparam int D1_IDX = 4;
  localparam int D2_IDX = 5;
  localparam int D3_IDX = 6;

  typedef enum logic {
    S_LO = 1'b0,  // waiting for the low-nibble codeword
    S_HI = 1'b1   // low nibble held, waiting for the high-nibble codeword
  } state_t;

  typedef struct packed {
    logic             syn_nonzero;
    logic [NIB_W-1:0] nibble;
  } decode_t;

  // Syndrome decode. A non-zero syndrome names the (1-based) position of the
  // bit to flip; double errors land on a wrong position and are miscorrected.
  function automatic decode_t hamming74_decode(input logic [CW_W-1:0] cw);
    logic [CW_W-1:0] c;
    logic [2:0]      syn;
    decode_t         res;
    c      = cw;
    syn[0] = c[P1_IDX] ^ c[D0_IDX] ^ c[D1_IDX] ^ c[D3_IDX];
    syn[1] = c[P2_IDX] ^ c[D0_IDX] ^ c[D2_IDX] ^ c[D3_IDX];
    syn[2] = c[P4_IDX] ^ c[D1_IDX] ^ c[D2_IDX] ^ c[D3_IDX];
    for (int i = 0; i < CW_W; i++) begin
      if (syn == 3'(i + 1)) c[i] = ~c[i];
    end
    res.syn_nonzero = (syn != 3'd0);
    res.nibble      = {c[D3_IDX], c[D2_IDX], c[D1_IDX], c[D0_IDX]};
    return res;
  endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Synchronous byte FIFO with exact occupancy count.
//   clk, rst_n  : clock, synchronous active-low reset
//   push        : write push_data (accepted when not full, or when full and
//                 a pop is taken in the same cycle)
//   push_data   : byte to write
//   pop         : remove head entry (ignored while empty)
//   pop_data    : head entry, reads 0 while empty
//   full, empty : occupancy flags
//   level       : number of stored entries, 0..DEPTH
module uart_byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [7:0]                 push_data,
  input  logic                       pop,
  output logic [7:0]                 pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (level == '0);
  assign full  = (level == LVL_W'(DEPTH));

  // A pop frees the slot the simultaneous push needs when full.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Masked so the output is a defined 0 whenever nothing is stored.
  assign pop_data = empty ? 8'd0 : mem[rd_ptr];

  // NOTE: storage has no reset; entries are only visible once written, and
  // leaving it out keeps the array mappable to plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_byte_ctrl.sv
// Sequencer for the Hamming(7,4) UART receiver.
//   clk, rst_n     : clock, synchronous active-low reset
//   en             : controller enable (freezes pairing and tick generation)
//   rx_ena         : registered oversample enable tick to the receiver
//   rx_data_in     : receiver codeword
//   rx_valid_in    : receiver valid; each rising edge is one codeword event
//   m_data/m_valid : FIFO head byte / FIFO non-empty
//   m_ready        : consumer accepts the head byte
//   fifo_level     : FIFO occupancy
//   corrected_cnt  : corrected codewords, saturating at 255
//   timeout_err    : sticky, high nibble did not arrive in time
//   overflow_err   : sticky, byte dropped on a full FIFO
//   clr_err        : clears the sticky flags and corrected_cnt
module uart_rx_byte_ctrl
  import uart_pkg::*;
#(
  parameter int CLK_DIV       = 4,
  parameter int FIFO_DEPTH    = 4,
  parameter int TIMEOUT_TICKS = 256
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  output logic                          rx_ena,
  input  logic [CW_W-1:0]               rx_data_in,
  input  logic                          rx_valid_in,
  output logic [7:0]                    m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [7:0]                    corrected_cnt,
  output logic                          timeout_err,
  output logic                          overflow_err,
  input  logic                          clr_err
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int TO_W  = $clog2(TIMEOUT_TICKS + 1);

  logic [DIV_W-1:0] div_cnt;
  logic             prev_valid;
  logic             cw_event;
  decode_t          dec;

  state_t           state, state_nxt;
  logic [NIB_W-1:0] lo_nib, lo_nxt;
  logic [TO_W-1:0]  to_cnt, to_nxt;
  logic             to_fire;

  logic             fifo_push;
  logic [7:0]       fifo_push_data;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_drop;

  // ---------------------------------------------------------------- divider
  // NOTE: every clocked block uses non-blocking assignments so all registers
  // update together from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n || !en) begin
      div_cnt <= '0;
      rx_ena  <= 1'b0;
    end else if (div_cnt == DIV_W'(CLK_DIV - 1)) begin
      div_cnt <= '0;
      rx_ena  <= 1'b1;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
      rx_ena  <= 1'b0;
    end
  end

  // ------------------------------------------------------- codeword capture
  always_ff @(posedge clk) begin
    if (!rst_n) prev_valid <= 1'b0;
    else        prev_valid <= rx_valid_in;
  end

  // Rising edge of valid; ignored entirely while disabled.
  assign cw_event = en & rx_valid_in & ~prev_valid;
  assign dec      = hamming74_decode(rx_data_in);

  // -------------------------------------------------------- nibble pairing
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_LO;
      lo_nib <= '0;
      to_cnt <= '0;
    end else begin
      state  <= state_nxt;
      lo_nib <= lo_nxt;
      to_cnt <= to_nxt;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the block leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    lo_nxt    = lo_nib;
    to_nxt    = to_cnt;
    fifo_push = 1'b0;
    to_fire   = 1'b0;
    if (en) begin
      case (state)
        S_LO: begin
          if (cw_event) begin
            lo_nxt    = dec.nibble;
            to_nxt    = '0;
            state_nxt = S_HI;
          end
        end
        S_HI: begin
          // An event in the timeout cycle still completes the byte.
          if (cw_event) begin
            fifo_push = 1'b1;
            state_nxt = S_LO;
          end else if (rx_ena) begin
            if (to_cnt == TO_W'(TIMEOUT_TICKS - 1)) begin
              to_fire   = 1'b1;
              to_nxt    = '0;
              state_nxt = S_LO;
            end else begin
              to_nxt = to_cnt + TO_W'(1);
            end
          end
        end
        default: state_nxt = S_LO;
      endcase
    end
  end

  assign fifo_push_data = {dec.nibble, lo_nib};

  // ------------------------------------------------------------------ FIFO
  uart_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (fifo_push_data),
    .pop       (m_ready),
    .pop_data  (m_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign m_valid = ~fifo_empty;

  // Full implies non-empty, so m_ready alone decides whether a slot frees up.
  assign fifo_drop = fifo_push & fifo_full & ~m_ready;

  // ------------------------------------------------------ status / counters
  // A set or increment in the clearing cycle wins over clr_err.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      corrected_cnt <= 8'd0;
      timeout_err   <= 1'b0;
      overflow_err  <= 1'b0;
    end else begin
      if (cw_event && dec.syn_nonzero) begin
        if (clr_err)                    corrected_cnt <= 8'd1;
        else if (corrected_cnt != 8'hFF) corrected_cnt <= corrected_cnt + 8'd1;
      end else if (clr_err) begin
        corrected_cnt <= 8'd0;
      end

      if (to_fire)      timeout_err <= 1'b1;
      else if (clr_err) timeout_err <= 1'b0;

      if (fifo_drop)    overflow_err <= 1'b1;
      else if (clr_err) overflow_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_byte_ctrl.sv
module tb_uart_rx_byte_ctrl;

  localparam int CLK_DIV       = 4;
  localparam int FIFO_DEPTH    = 4;
  localparam int TIMEOUT_TICKS = 8;
  localparam int LVL_W         = $clog2(FIFO_DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic             rx_ena;
  logic [6:0]       rx_data_in = 7'd0;
  logic             rx_valid_in = 1'b0;
  logic [7:0]       m_data;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic [LVL_W-1:0] fifo_level;
  logic [7:0]       corrected_cnt;
  logic             timeout_err;
  logic             overflow_err;
  logic             clr_err = 1'b0;

  always #5 clk = ~clk;

  uart_rx_byte_ctrl #(
    .CLK_DIV       (CLK_DIV),
    .FIFO_DEPTH    (FIFO_DEPTH),
    .TIMEOUT_TICKS (TIMEOUT_TICKS)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (en),
    .rx_ena        (rx_ena),
    .rx_data_in    (rx_data_in),
    .rx_valid_in   (rx_valid_in),
    .m_data        (m_data),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .fifo_level    (fifo_level),
    .corrected_cnt (corrected_cnt),
    .timeout_err   (timeout_err),
    .overflow_err  (overflow_err),
    .clr_err       (clr_err)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;
  bit         have_lo = 0;
  logic [3:0] lo_model = 4'd0;
  int         exp_corr = 0;
  bit         exp_timeout = 0;
  bit         exp_ovf = 0;
  bit         rand_mode = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference code: systematic Hamming(7,4) encoder.
  function automatic logic [6:0] encode(input logic [3:0] n);
    logic [6:0] c;
    c[2] = n[0]; c[4] = n[1]; c[5] = n[2]; c[6] = n[3];
    c[0] = c[2] ^ c[4] ^ c[6];
    c[1] = c[2] ^ c[5] ^ c[6];
    c[3] = c[4] ^ c[5] ^ c[6];
    return c;
  endfunction

  // Nearest-codeword decode: the code is perfect, so every 7-bit word is
  // within distance 1 of exactly one codeword.
  task automatic ref_decode(input logic [6:0] cw, output logic [3:0] nib, output bit corr);
    nib  = 4'd0;
    corr = 0;
    for (int n = 0; n < 16; n++) begin
      int d;
      d = $countones(encode(4'(n)) ^ cw);
      if (d <= 1) begin
        nib  = 4'(n);
        corr = (d == 1);
      end
    end
  endtask

  task automatic model_event(input logic [6:0] cw, input bit clr);
    logic [3:0] nib;
    bit         corr;
    ref_decode(cw, nib, corr);
    if (clr) begin
      exp_timeout = 0;
      exp_ovf     = 0;
      exp_corr    = 0;
    end
    if (corr && exp_corr < 255) exp_corr++;
    if (!have_lo) begin
      lo_model = nib;
      have_lo  = 1;
    end else begin
      have_lo = 0;
      if (exp_q.size() >= FIFO_DEPTH && !m_ready) exp_ovf = 1;
      else exp_q.push_back({nib, lo_model});
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_mode) m_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic pulse(input logic [6:0] cw, input bit clr);
    rx_data_in  = cw;
    rx_valid_in = 1'b1;
    clr_err     = clr;
    model_event(cw, clr);
    step();
    rx_valid_in = 1'b0;
    clr_err     = 1'b0;
  endtask

  task automatic send(input logic [6:0] cw);
    pulse(cw, 1'b0);
    step();
  endtask

  task automatic clear_errs();
    clr_err     = 1'b1;
    exp_timeout = 0;
    exp_ovf     = 0;
    exp_corr    = 0;
    step();
    clr_err = 1'b0;
  endtask

  task automatic check_status(input string tag);
    check({tag, "_corrected_cnt"}, 32'(corrected_cnt), 32'(exp_corr));
    check({tag, "_timeout_err"}, 32'(timeout_err), 32'(exp_timeout));
    check({tag, "_overflow_err"}, 32'(overflow_err), 32'(exp_ovf));
  endtask

  task automatic drain(input string tag);
    rand_mode = 0;
    m_ready   = 1'b1;
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) step();
    check({tag, "_drain_left"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_drain_level"}, 32'(fifo_level), 32'd0);
  endtask

  task automatic timeout_test();
    int ticks = 0;
    int cyc   = 0;
    int last  = -1;
    bit done  = 0;
    m_ready = 1'b1;
    pulse(7'h2D, 1'b0);
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      cyc++;
      if (rx_ena) begin
        ticks++;
        if (last >= 0) check("tick_period", 32'(cyc - last), 32'(CLK_DIV));
        last = cyc;
        if (ticks == TIMEOUT_TICKS) begin
          check("timeout_before_limit", 32'(timeout_err), 32'd0);
          @(negedge clk);
          check("timeout_at_limit", 32'(timeout_err), 32'd1);
          done = 1;
        end
      end
    end
    if (!done) check("timeout_ticks_seen", 32'(ticks), 32'(TIMEOUT_TICKS));
    have_lo     = 0;
    exp_timeout = 1;
    step();
  endtask

  // Scoreboard monitor: a handshake at the next edge pops the head byte.
  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL m_data_unexpected: got 0x%0h, expected no byte", m_data);
      end else begin
        mon_exp = exp_q.pop_front();
        check("m_data", 32'(m_data), 32'(mon_exp));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    logic [6:0] cw;
    logic [3:0] n;
    int         r;

    // Reset state
    repeat (3) step();
    check("rst_rx_ena", 32'(rx_ena), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    check("rst_fifo_level", 32'(fifo_level), 32'd0);
    check_status("rst");
    rst_n = 1'b1;
    en    = 1'b1;
    step();

    // Clean byte
    send(7'h2D);
    check("clean_no_valid_yet", 32'(m_valid), 32'd0);
    pulse(7'h52, 1'b0);
    check("clean_m_valid", 32'(m_valid), 32'd1);
    check("clean_m_data", 32'(m_data), 32'hA5);
    step();
    check_status("clean");
    drain("clean");

    // Corrected error, then correction coinciding with clr_err
    send(7'h29);
    send(7'h52);
    check_status("corr");
    pulse(7'h29, 1'b1);
    step();
    check_status("corr_clr");
    send(7'h52);
    drain("corr");
    clear_errs();
    check_status("corr_cleared");

    // Held valid yields one event
    m_ready     = 1'b0;
    rx_data_in  = 7'h2D;
    rx_valid_in = 1'b1;
    model_event(7'h2D, 1'b0);
    repeat (20) step();
    rx_valid_in = 1'b0;
    step();
    send(7'h52);
    check("held_level", 32'(fifo_level), 32'd1);
    drain("held");

    // Timeout, then re-pairing from scratch
    timeout_test();
    send(7'h52);
    send(7'h2D);
    drain("timeout");
    check_status("timeout");
    clear_errs();
    check_status("timeout_cleared");

    // Disabled controller ignores events and stops ticks
    en = 1'b0;
    step();
    step();
    check("dis_rx_ena", 32'(rx_ena), 32'd0);
    rx_data_in  = 7'h2D;
    rx_valid_in = 1'b1;
    step();
    rx_valid_in = 1'b0;
    step();
    en = 1'b1;
    send(7'h52);
    send(7'h2D);
    drain("disabled");

    // Overflow: five bytes into a four-deep FIFO
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom);
      send(encode(b[3:0]));
      send(encode(b[7:4]));
    end
    check("ovf_level", 32'(fifo_level), 32'(FIFO_DEPTH));
    check_status("ovf");

    // Full FIFO with a pop in the push cycle
    clear_errs();
    check_status("full_cleared");
    b = 8'($urandom);
    send(encode(b[3:0]));
    m_ready = 1'b1;
    pulse(encode(b[7:4]), 1'b0);
    m_ready = 1'b0;
    check("full_pop_level", 32'(fifo_level), 32'(FIFO_DEPTH));
    check_status("full_pop");
    drain("full_pop");

    // Reset mid-frame drops the pending nibble and FIFO contents
    m_ready = 1'b0;
    send(encode(4'h3));
    send(encode(4'hC));
    send(encode(4'h7));
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    have_lo = 0;
    exp_q.delete();
    exp_timeout = 0;
    exp_ovf     = 0;
    exp_corr    = 0;
    check("midrst_m_valid", 32'(m_valid), 32'd0);
    check("midrst_level", 32'(fifo_level), 32'd0);
    check_status("midrst");
    step();
    send(7'h52);
    send(7'h2D);
    drain("midrst");

    // Randomized codewords with random backpressure
    rand_mode = 1;
    for (int p = 0; p < 80; p++) begin
      n  = 4'($urandom);
      cw = encode(n);
      r  = int'($urandom_range(0, 9));
      if (r < 4) cw = cw ^ (7'd1 << $urandom_range(0, 6));
      else if (r == 9) cw = 7'($urandom);
      send(cw);
      repeat ($urandom_range(0, 2)) step();
      if (p % 2 == 1) check_status("rand");
    end
    drain("rand");
    check_status("rand_end");

    // Counter saturation
    clear_errs();
    m_ready = 1'b1;
    for (int k = 0; k < 260; k++) begin
      n = 4'($urandom);
      send(encode(n) ^ (7'd1 << (k % 7)));
    end
    drain("sat");
    check_status("sat");
    check("sat_value", 32'(corrected_cnt), 32'd255);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
